// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the iterative divider
package div_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default operand/result width
  localparam int DATA_LEN_DEF = 32;

  // Result select: quotient or remainder
  localparam logic SEL_QUO = 1'b0;
  localparam logic SEL_REM = 1'b1;

endpackage

// File: rtl/div_sub.sv
// rtl/div_sub.sv - shared W-bit adder used as subtractor by the divider (op_a + ~op_b + cin)
module div_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // cout = 1 means no borrow when cin = 1
  assign {cout, sum} = {1'b0, op_a} + {1'b0, ~op_b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/div_iter_ctrl.sv
// rtl/div_iter_ctrl.sv - radix-2 restoring divider controller for DIV/DIVU/REM/REMU
module div_iter_ctrl
  import div_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic                in_rem,
  input  logic [DATA_LEN-1:0] in_a,
  input  logic [DATA_LEN-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_result
);

  localparam int CNT_W = $clog2(DATA_LEN) + 1;
  localparam logic [DATA_LEN-1:0] MOST_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};

  // Two's-complement negation, kept apart from the shared subtractor
  function automatic logic [DATA_LEN-1:0] negate(input logic [DATA_LEN-1:0] x);
    return ~x + DATA_LEN'(1);
  endfunction

  state_t              state, state_nxt;
  logic                sel_rem;
  logic                sign_q, sign_r;
  logic [DATA_LEN-1:0] qsh, rem, divisor;
  logic [CNT_W-1:0]    cnt;

  logic                div_zero, div_ovf;
  logic [DATA_LEN-1:0] a_abs, b_abs;
  logic [DATA_LEN:0]   shifted, sub_sum;
  logic                sub_cout, take;

  assign div_zero = (in_b == '0);
  assign div_ovf  = in_signed && (in_a == MOST_NEG) && (in_b == '1);
  assign a_abs    = (in_signed && in_a[DATA_LEN-1]) ? negate(in_a) : in_a;
  assign b_abs    = (in_signed && in_b[DATA_LEN-1]) ? negate(in_b) : in_b;

  assign shifted = {rem, qsh[DATA_LEN-1]};

  div_sub #(.W(DATA_LEN + 1)) u_div_sub (
    .op_a (shifted),
    .op_b ({1'b0, divisor}),
    .cin  (1'b1),
    .sum  (sub_sum),
    .cout (sub_cout)
  );

  // While R < divisor the difference always fits in R; the top-bit term is a guard only
  assign take = sub_cout && !sub_sum[DATA_LEN];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush always wins
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_nxt = (div_zero || div_ovf) ? DONE : CALC;
        CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_rem <= SEL_QUO;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      qsh     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (in_valid) begin
          sel_rem <= in_rem;
          sign_q  <= in_signed & (in_a[DATA_LEN-1] ^ in_b[DATA_LEN-1]);
          sign_r  <= in_signed & in_a[DATA_LEN-1];
          if (div_zero) begin
            qsh <= '1;
            rem <= in_a;
          end else if (div_ovf) begin
            qsh <= in_a;
            rem <= '0;
          end else begin
            qsh     <= a_abs;
            divisor <= b_abs;
            rem     <= '0;
            cnt     <= CNT_W'(DATA_LEN);
          end
        end
        CALC: begin
          rem <= take ? sub_sum[DATA_LEN-1:0] : shifted[DATA_LEN-1:0];
          qsh <= {qsh[DATA_LEN-2:0], take};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          qsh <= sign_q ? negate(qsh) : qsh;
          rem <= sign_r ? negate(rem) : rem;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; result is zero whenever not valid
  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    out_result = '0;
    if (state == DONE) out_result = (sel_rem == SEL_REM) ? rem : qsh;
  end

endmodule

// File: tb/tb_div_iter_ctrl.sv
// tb/tb_div_iter_ctrl.sv - self-checking bench for div_iter_ctrl
module tb_div_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic        in_rem;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int checks = 0;
  int errors = 0;

  div_iter_ctrl #(.DATA_LEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_rem     (in_rem),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic s, input logic r,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, rm;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; rm = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; rm = 32'd0;
    end else if (s) begin
      q  = $signed(a) / $signed(b);
      rm = $signed(a) % $signed(b);
    end else begin
      q = a / b; rm = a % b;
    end
    return r ? rm : q;
  endfunction

  task automatic run_op(input logic s, input logic r, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp_res;
    int lat;
    int k;
    exp_res = model(s, r, a, b);
    lat = (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_signed = s; in_rem = r; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    in_signed = ~s; in_rem = ~r;
    k = 1;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("result", out_result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, exp_res);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_rem = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 0);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 1'b0, 32'd1000, 32'd9, 10);

    // Flush together with a request in IDLE: request must be dropped
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_signed = 1'b0; in_rem = 1'b0; in_a = 32'd5; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", 32'(in_ready), 32'd1);
    chk("flush_idle_valid", 32'(out_valid), 32'd0);
    expect_quiet("flush_idle_quiet", 5);

    // Flush in cycle 15 of CALC
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; in_rem = 1'b0; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    chk("calc_busy", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_ready", 32'(in_ready), 32'd1);
    chk("flush_calc_valid", 32'(out_valid), 32'd0);
    expect_quiet("flush_calc_quiet", 40);
    run_op(1'b0, 1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b1; in_rem = 1'b1; in_a = 32'hFFFF_0000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("arst_quiet", 40);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 14; n++) begin
      logic        s, r;
      logic [31:0] a, b;
      int          mode;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = $urandom;
      mode = int'($urandom_range(0, 4));
      case (mode)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op(s, r, a, b, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
